// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin arbiter merging N valid/ready streams into one.
// Optional STREAM_ARB_ID_EN adds m_id_o carrying the granted source index.
module stream_rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned DW = 32,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*DW-1:0] s_data_i,
  input  logic [N-1:0]    s_valid_i,
  input  logic [N-1:0]    s_last_i,
  output logic [N-1:0]    s_ready_o,
  output logic [DW-1:0]   m_data_o,
  output logic            m_valid_o,
  output logic            m_last_o,
  input  logic            m_ready_i
`ifdef STREAM_ARB_ID_EN
  ,
  output logic [IW-1:0]   m_id_o
`endif
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [IW-1:0] pick_lo, pick_hi, pick;
  logic          any_hi;
  logic [DW-1:0] sel_data;
  logic          sel_valid, sel_last;
  logic          busy;

  // Lowest valid index at or above ptr wins; otherwise wrap to lowest valid overall.
  always_comb begin
    pick_lo = '0;
    pick_hi = '0;
    any_hi  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (s_valid_i[k]) begin
        pick_lo = IW'(k);
        if (IW'(k) >= ptr_q) begin
          pick_hi = IW'(k);
          any_hi  = 1'b1;
        end
      end
    end
    pick = any_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (grant_q == IW'(k)) begin
        sel_data  = s_data_i[k*DW +: DW];
        sel_valid = s_valid_i[k];
        sel_last  = s_last_i[k];
      end
    end
  end

  // Outputs are gated by rst_n so a reset mid-packet silences the port at once.
  assign busy      = (state_q == StBusy) && rst_n;
  assign m_valid_o = busy && sel_valid;
  assign m_data_o  = m_valid_o ? sel_data : '0;
  assign m_last_o  = m_valid_o && sel_last;

  always_comb begin
    s_ready_o = '0;
    for (int k = 0; k < N; k++) begin
      s_ready_o[k] = busy && m_ready_i && (grant_q == IW'(k));
    end
  end

`ifdef STREAM_ARB_ID_EN
  assign m_id_o = busy ? grant_q : '0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle: begin
        if (|s_valid_i) begin
          grant_d = pick;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (m_valid_o && m_ready_i && m_last_o) begin
          state_d = StIdle;
          ptr_d   = (grant_q == IW'(N - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule
